// File: rtl/legendre_rom_arbiter.sv
// Purpose : shares one synchronous Legendre ROM among NREQ Weil PRN requester ports.
// Latency : grant and ROM select in cycle T (combinational); legendre_data valid in T+1.
// Backpr. : requesters hold req_rd until granted; rom_busy blocks all grants, waits keep counting.
// Option  : define LEGENDRE_ARB_STAT_EN to build the stat_max_wait statistic register.
module legendre_rom_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_WAIT = 8,
  parameter int AW       = 10
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_preempt,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      req_read_valid,
  output logic [15:0]          legendre_data,
  input  logic                 rom_busy,
  output logic                 rom_rd,
  output logic [AW-1:0]        rom_addr,
  input  logic [15:0]          rom_data,
  input  logic                 stat_clr,
  output logic [7:0]           stat_max_wait
);

  localparam int              PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]      MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [PW:0]     NREQ_C     = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(NREQ - 1);

  // Arbitration state
  logic [PW-1:0]   rr_ptr;
  logic [7:0]      wait_cnt [NREQ];
  logic [AW-1:0]   last_addr;
  logic            dphase;
  logic [15:0]     data_q;

  // Per-port views of the request bundle
  logic [AW-1:0]   addr_arr [NREQ];
  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] pre_req;

  // Winner of the current cycle
  logic            grant_any;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     rr_sum;
  logic [PW-1:0]   rr_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
  end

  assign pre_req = req_rd & req_preempt;

  // A port is starved once it has waited MAX_WAIT cycles with its request up
  always_comb begin
    starved = '0;
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req_rd[i] && (wait_cnt[i] == MAX_WAIT_C);
    end
  end

  // Three-tier priority pick: starved (fixed, lowest index), then preempt RR, then plain RR
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    if (!rom_busy) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && starved[i]) begin
          grant_any = 1'b1;
          gnt_idx   = PW'(i);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        rr_sum = {1'b0, rr_ptr} + (PW+1)'(k);
        if (rr_sum >= NREQ_C) begin
          rr_sum = rr_sum - NREQ_C;
        end
        rr_idx = rr_sum[PW-1:0];
        if (!grant_any && pre_req[rr_idx]) begin
          grant_any = 1'b1;
          gnt_idx   = rr_idx;
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        rr_sum = {1'b0, rr_ptr} + (PW+1)'(k);
        if (rr_sum >= NREQ_C) begin
          rr_sum = rr_sum - NREQ_C;
        end
        rr_idx = rr_sum[PW-1:0];
        if (!grant_any && req_rd[rr_idx]) begin
          grant_any = 1'b1;
          gnt_idx   = rr_idx;
        end
      end
    end
  end

  // One-hot grant back to the requesters and address mux toward the ROM
  always_comb begin
    req_read_valid = '0;
    if (grant_any) begin
      req_read_valid[gnt_idx] = 1'b1;
    end
    rom_rd   = grant_any;
    rom_addr = grant_any ? addr_arr[gnt_idx] : last_addr;
  end

  // Pointer advance, address hold and data-phase tracking
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr    <= '0;
      last_addr <= '0;
      dphase    <= 1'b0;
      data_q    <= '0;
    end else begin
      dphase <= grant_any;
      if (grant_any) begin
        rr_ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
        last_addr <= addr_arr[gnt_idx];
      end
      if (dphase) begin
        data_q <= rom_data;
      end
    end
  end

  // ROM word passes straight through in the data phase, otherwise the last word is held
  assign legendre_data = dphase ? rom_data : data_q;

  // Saturating wait counters, counting through rom_busy as well
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_rd[i] || req_read_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != MAX_WAIT_C) begin
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
      end
    end
  end

`ifdef LEGENDRE_ARB_STAT_EN
  logic [7:0] stat_q;
  logic [7:0] gnt_wait;

  assign gnt_wait = wait_cnt[gnt_idx];

  // High-water mark of the wait seen by granted ports; clear beats update
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_q <= '0;
    end else if (stat_clr) begin
      stat_q <= '0;
    end else if (grant_any && (gnt_wait > stat_q)) begin
      stat_q <= gnt_wait;
    end
  end

  assign stat_max_wait = stat_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign stat_max_wait   = 8'd0;
`endif

endmodule

// File: tb/tb_legendre_rom_arbiter.sv
// Purpose : directed checks of legendre_rom_arbiter with a behavioural synchronous ROM.
// Latency : inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
// Backpr. : requesters hold req_rd until their grant cycle, then drop it.
module tb_legendre_rom_arbiter;

  localparam int NREQ = 8;
  localparam int AW   = 10;

  logic              clk;
  logic              rst_b;
  logic [NREQ-1:0]   req_rd;
  logic [NREQ-1:0]   req_preempt;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_read_valid;
  logic [15:0]       legendre_data;
  logic              rom_busy;
  logic              rom_rd;
  logic [AW-1:0]     rom_addr;
  logic [15:0]       rom_data = 16'h0000;
  logic              stat_clr;
  logic [7:0]        stat_max_wait;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef LEGENDRE_ARB_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  legendre_rom_arbiter #(.NREQ(NREQ), .MAX_WAIT(8), .AW(AW)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .req_rd         (req_rd),
    .req_preempt    (req_preempt),
    .req_addr       (req_addr),
    .req_read_valid (req_read_valid),
    .legendre_data  (legendre_data),
    .rom_busy       (rom_busy),
    .rom_rd         (rom_rd),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stat_clr       (stat_clr),
    .stat_max_wait  (stat_max_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port i reads 0x100+i, except port 3 which reads 0x12A
  always_comb begin
    req_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = (i == 3) ? 10'h12A : (10'h100 + AW'(i));
    end
  end

  // ROM contents: 0xBEEF at 0x12A, 0xA000|addr elsewhere
  function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
    return (a == 10'h12A) ? 16'hBEEF : (16'hA000 | {6'd0, a});
  endfunction

  // Synchronous ROM: word appears the cycle after chip select
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_word(rom_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0]  rr_exp [6];
  logic [15:0] rr_dat [5];
  logic [7:0]  st_exp [9];

  initial begin
    rr_exp = '{8'h01, 8'h04, 8'h20, 8'h01, 8'h04, 8'h20};
    rr_dat = '{16'hA100, 16'hA102, 16'hA105, 16'hA100, 16'hA102};
    st_exp = '{8'h02, 8'h04, 8'h02, 8'h04, 8'h02, 8'h04, 8'h02, 8'h04, 8'h01};

    rst_b = 1'b0; req_rd = '0; req_preempt = '0; rom_busy = 1'b0; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rv",   req_read_valid, 32'h0);
    chk("rst_rd",   rom_rd,         32'h0);
    chk("rst_addr", rom_addr,       32'h0);
    chk("rst_data", legendre_data,  32'h0);
    chk("rst_stat", stat_max_wait,  32'h0);
    @(posedge clk);
    #1 rst_b = 1'b1;

    // Single request on port 3
    tick(); req_rd = 8'h08; #1;
    chk("single_rv",   req_read_valid, 32'h08);
    chk("single_rd",   rom_rd,         32'h1);
    chk("single_addr", rom_addr,       32'h12A);
    tick(); req_rd = 8'h00; #1;
    chk("single_data", legendre_data,  32'hBEEF);
    chk("idle_rv",     req_read_valid, 32'h0);
    chk("idle_rd",     rom_rd,         32'h0);
    chk("addr_hold",   rom_addr,       32'h12A);

    // rr_ptr is now 4: ports 3 and 5 together must pick 5
    tick(); req_rd = 8'h28; #1;
    chk("rr4_rv",   req_read_valid, 32'h20);
    chk("rr4_addr", rom_addr,       32'h105);
    tick(); req_rd = 8'h08; #1;
    chk("rr4_next", req_read_valid, 32'h08);
    chk("rr4_data", legendre_data,  32'hA105);
    tick(); req_rd = 8'h00; #1;
    chk("p3_data",   legendre_data, 32'hBEEF);
    tick(); #1;
    chk("data_hold", legendre_data, 32'hBEEF);

    // Reset during a data phase
    tick(); req_rd = 8'h01; #1;
    chk("pre_rst_rv", req_read_valid, 32'h01);
    tick(); req_rd = 8'h00; rst_b = 1'b0; #1;
    chk("mid_rst_data", legendre_data, 32'h0);
    tick(); rst_b = 1'b1;

    // Preempt wins over plain round-robin
    tick(); req_rd = 8'h42; req_preempt = 8'h40; #1;
    chk("pre_first", req_read_valid, 32'h40);
    tick(); req_rd = 8'h02; req_preempt = 8'h00; #1;
    chk("pre_second", req_read_valid, 32'h02);
    chk("pre_data",   legendre_data,  32'hA106);
    tick(); req_rd = 8'h00; #1;
    chk("pre_data2",  legendre_data,  32'hA101);

    // Reset puts rr_ptr back at 0, then continuous requests on 0, 2, 5
    tick(); rst_b = 1'b0;
    tick(); rst_b = 1'b1;
    tick(); req_rd = 8'h25;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_seq", req_read_valid, 32'(rr_exp[c]));
      if (c > 0) chk("rr_data", legendre_data, 32'(rr_dat[c-1]));
      tick();
    end
    req_rd = 8'h00; #1;
    chk("rr_last_data", legendre_data, 32'hA105);
    chk("rr_stat",      stat_max_wait, STAT ? 32'h2 : 32'h0);
    tick(); stat_clr = 1'b1;
    tick(); stat_clr = 1'b0; #1;
    chk("clr1_stat", stat_max_wait, 32'h0);

    // Starvation: port 0 against preempt ports 1 and 2, rr_ptr = 6
    tick(); req_rd = 8'h07; req_preempt = 8'h06;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk("starve_seq", req_read_valid, 32'(st_exp[c]));
      tick();
    end
    req_rd = 8'h00; req_preempt = 8'h00; #1;
    chk("starve_data", legendre_data, 32'hA100);
    chk("starve_stat", stat_max_wait, STAT ? 32'h8 : 32'h0);
    tick(); stat_clr = 1'b1; #1;
    chk("clr_pending", stat_max_wait, STAT ? 32'h8 : 32'h0);
    tick(); stat_clr = 1'b0; #1;
    chk("clr2_stat", stat_max_wait, 32'h0);

    // rom_busy for 5 cycles with ports 4 and 7 pending, rr_ptr = 1
    tick(); req_rd = 8'h90; rom_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("busy_rv",   req_read_valid, 32'h0);
      chk("busy_rd",   rom_rd,         32'h0);
      chk("busy_addr", rom_addr,       32'h100);
      tick();
    end
    rom_busy = 1'b0; #1;
    chk("resume_rv",   req_read_valid, 32'h10);
    chk("resume_addr", rom_addr,       32'h104);
    tick(); req_rd = 8'h80; rom_busy = 1'b1; #1;
    chk("busy_t1_rv",   req_read_valid, 32'h0);
    chk("busy_t1_data", legendre_data,  32'hA104);
    chk("busy_stat",    stat_max_wait,  STAT ? 32'h5 : 32'h0);
    tick(); rom_busy = 1'b0; stat_clr = 1'b1; #1;
    chk("p7_rv", req_read_valid, 32'h80);
    tick(); stat_clr = 1'b0; req_rd = 8'h00; #1;
    chk("clr_prio", stat_max_wait, 32'h0);
    chk("p7_data",  legendre_data, 32'hA107);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
